// File: rtl/signmag_operand_sequencer.sv
// Sign-magnitude add/subtract/compare front end: collects A then B+op, holds result until taken.
// Optional: define SIGNMAG_SATURATE_EN to clamp overflowed magnitudes to all-ones.
module signmag_operand_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [W-1:0]     in_mag,
  input  logic             in_op,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [W-1:0]     out_mag,
  output logic             out_of,
  output logic             out_eq,
  output logic             out_lt,
  output logic [CNT_W-1:0] op_count
);

  // state | meaning
  // S_A   | waiting for operand A beat
  // S_B   | A latched, waiting for operand B + op beat
  // S_OUT | result registered, waiting for consumer handoff
  localparam logic [1:0] S_A   = 2'd0;
  localparam logic [1:0] S_B   = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;

  logic [1:0]          state;
  logic                a_sign;
  logic [W-1:0]        a_mag;
  logic                accept;
  logic                handoff;

  logic                b_eff;
  logic [W:0]          sum;
  logic                r_sign;
  logic [W-1:0]        r_mag;
  logic                r_of;
  logic signed [W+1:0] a_val;
  logic signed [W+1:0] b_val;

  assign in_ready  = (state != S_OUT);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;

  always_comb begin
    b_eff = in_sign ^ ~in_op;
    if (a_sign == b_eff) begin
      sum    = {1'b0, a_mag} + {1'b0, in_mag};
      r_sign = a_sign;
    end else if (a_mag >= in_mag) begin
      sum    = {1'b0, a_mag} - {1'b0, in_mag};
      r_sign = a_sign;
    end else begin
      sum    = {1'b0, in_mag} - {1'b0, a_mag};
      r_sign = b_eff;
    end
    // a zero result is always reported as +0
    if (sum == '0) r_sign = 1'b0;
    r_of = sum[W];
`ifdef SIGNMAG_SATURATE_EN
    r_mag = r_of ? {W{1'b1}} : sum[W-1:0];
`else
    r_mag = sum[W-1:0];
`endif
    // compare on the original operands, so op does not affect eq/lt
    a_val = a_sign  ? -$signed({2'b00, a_mag})  : $signed({2'b00, a_mag});
    b_val = in_sign ? -$signed({2'b00, in_mag}) : $signed({2'b00, in_mag});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_A;
      a_sign   <= 1'b0;
      a_mag    <= '0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_of   <= 1'b0;
      out_eq   <= 1'b0;
      out_lt   <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        S_A: begin
          if (in_clear) begin
            a_sign <= 1'b0;
            a_mag  <= '0;
          end else if (accept) begin
            a_sign <= in_sign;
            a_mag  <= in_mag;
            state  <= S_B;
          end
        end
        S_B: begin
          if (in_clear) begin
            a_sign <= 1'b0;
            a_mag  <= '0;
            state  <= S_A;
          end else if (accept) begin
            out_sign <= r_sign;
            out_mag  <= r_mag;
            out_of   <= r_of;
            out_eq   <= (a_val == b_val);
            out_lt   <= (a_val < b_val);
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (handoff) begin
            op_count <= op_count + 1'b1;
            state    <= S_A;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule
